// File: rtl/complex_multiplier_axis.sv
`timescale 1ns/1ps
// Pipelined signed complex multiplier with AXI-Stream operand/product ports.
// Stages: operand hold register, four partial products, add/sub + rescale.
module complex_multiplier_axis #(
  parameter int unsigned OPERAND_WIDTH_A   = 16,
  parameter int unsigned OPERAND_WIDTH_B   = 16,
  parameter int unsigned OPERAND_WIDTH_OUT = 33,
  parameter bit          BYTE_ALIGNED      = 1'b0,
  parameter bit          BLOCKING          = 1'b1,
  localparam int unsigned PWA = BYTE_ALIGNED ? 8 * ((OPERAND_WIDTH_A + 7) / 8) : OPERAND_WIDTH_A,
  localparam int unsigned PWB = BYTE_ALIGNED ? 8 * ((OPERAND_WIDTH_B + 7) / 8) : OPERAND_WIDTH_B,
  localparam int unsigned PWO = BYTE_ALIGNED ? 8 * ((OPERAND_WIDTH_OUT + 7) / 8) : OPERAND_WIDTH_OUT
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic [2*PWA-1:0] s_axis_a_tdata,
  input  logic             s_axis_a_tvalid,
  output logic             s_axis_a_tready,
  input  logic [2*PWB-1:0] s_axis_b_tdata,
  input  logic             s_axis_b_tvalid,
  output logic             s_axis_b_tready,
  output logic [2*PWO-1:0] m_axis_dout_tdata,
  output logic             m_axis_dout_tvalid,
  input  logic             m_axis_dout_tready
);

  localparam int unsigned AW     = OPERAND_WIDTH_A;
  localparam int unsigned BW     = OPERAND_WIDTH_B;
  localparam int unsigned OW     = OPERAND_WIDTH_OUT;
  localparam int unsigned PROD_W = AW + BW;
  localparam int unsigned FULL_W = AW + BW + 1;
  localparam int unsigned SHIFT  = (OW < FULL_W) ? (FULL_W - OW) : 0;
  localparam int unsigned EXT_W  = (PWO > FULL_W) ? PWO : FULL_W;

  logic                     r_active;
  logic                     r_a_full;
  logic                     r_b_full;
  logic signed [AW-1:0]     r_a_re;
  logic signed [AW-1:0]     r_a_im;
  logic signed [BW-1:0]     r_b_re;
  logic signed [BW-1:0]     r_b_im;
  logic                     r_p_valid;
  logic signed [PROD_W-1:0] r_p_rr;
  logic signed [PROD_W-1:0] r_p_ii;
  logic signed [PROD_W-1:0] r_p_ri;
  logic signed [PROD_W-1:0] r_p_ir;
  logic                     r_out_valid;
  logic [PWO-1:0]           r_out_re;
  logic [PWO-1:0]           r_out_im;

  logic                     w_adv;
  logic                     w_pair;
  logic                     w_a_fire;
  logic                     w_b_fire;
  logic                     w_a_load;
  logic                     w_b_load;
  logic signed [FULL_W-1:0] w_re_full;
  logic signed [FULL_W-1:0] w_im_full;
  logic signed [FULL_W-1:0] w_re_sh;
  logic signed [FULL_W-1:0] w_im_sh;
  logic signed [EXT_W-1:0]  w_re_ext;
  logic signed [EXT_W-1:0]  w_im_ext;
  logic                     w_unused;

  // Whole pipeline stalls together on output backpressure
  assign w_adv    = BLOCKING ? (!r_out_valid || m_axis_dout_tready) : 1'b1;
  assign w_pair   = r_a_full && r_b_full && w_adv;

  assign s_axis_a_tready = r_active && (!BLOCKING || !r_a_full);
  assign s_axis_b_tready = r_active && (!BLOCKING || !r_b_full);

  assign w_a_fire = s_axis_a_tvalid && s_axis_a_tready;
  assign w_b_fire = s_axis_b_tvalid && s_axis_b_tready;
  assign w_a_load = BLOCKING ? w_a_fire : (w_a_fire && w_b_fire);
  assign w_b_load = BLOCKING ? w_b_fire : (w_a_fire && w_b_fire);

  // Full-precision sums, then truncating rescale or sign extension
  assign w_re_full = FULL_W'(r_p_rr) - FULL_W'(r_p_ii);
  assign w_im_full = FULL_W'(r_p_ri) + FULL_W'(r_p_ir);
  assign w_re_sh   = w_re_full >>> SHIFT;
  assign w_im_sh   = w_im_full >>> SHIFT;
  assign w_re_ext  = EXT_W'(w_re_sh);
  assign w_im_ext  = EXT_W'(w_im_sh);

  assign m_axis_dout_tdata  = {r_out_im, r_out_re};
  assign m_axis_dout_tvalid = r_out_valid;

  // Pad bits, unused sign-extension bits and tready in non-blocking mode
  assign w_unused = ^{s_axis_a_tdata, s_axis_b_tdata, m_axis_dout_tready, w_re_ext, w_im_ext};

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_active    <= 1'b0;
      r_a_full    <= 1'b0;
      r_b_full    <= 1'b0;
      r_a_re      <= '0;
      r_a_im      <= '0;
      r_b_re      <= '0;
      r_b_im      <= '0;
      r_p_valid   <= 1'b0;
      r_p_rr      <= '0;
      r_p_ii      <= '0;
      r_p_ri      <= '0;
      r_p_ir      <= '0;
      r_out_valid <= 1'b0;
      r_out_re    <= '0;
      r_out_im    <= '0;
    end else begin
      r_active <= 1'b1;

      if (BLOCKING) begin
        if (w_a_fire)    r_a_full <= 1'b1;
        else if (w_pair) r_a_full <= 1'b0;
        if (w_b_fire)    r_b_full <= 1'b1;
        else if (w_pair) r_b_full <= 1'b0;
      end else begin
        r_a_full <= w_a_fire && w_b_fire;
        r_b_full <= w_a_fire && w_b_fire;
      end

      if (w_a_load) begin
        r_a_re <= s_axis_a_tdata[AW-1:0];
        r_a_im <= s_axis_a_tdata[PWA+AW-1:PWA];
      end
      if (w_b_load) begin
        r_b_re <= s_axis_b_tdata[BW-1:0];
        r_b_im <= s_axis_b_tdata[PWB+BW-1:PWB];
      end

      if (w_adv) begin
        r_p_valid <= w_pair;
        if (w_pair) begin
          r_p_rr <= PROD_W'(r_a_re) * PROD_W'(r_b_re);
          r_p_ii <= PROD_W'(r_a_im) * PROD_W'(r_b_im);
          r_p_ri <= PROD_W'(r_a_re) * PROD_W'(r_b_im);
          r_p_ir <= PROD_W'(r_a_im) * PROD_W'(r_b_re);
        end
        r_out_valid <= r_p_valid;
        if (r_p_valid) begin
          r_out_re <= w_re_ext[PWO-1:0];
          r_out_im <= w_im_ext[PWO-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_complex_multiplier_axis.sv
`timescale 1ns/1ps
// Directed/self-checking bench for complex_multiplier_axis across four parameter sets.
module tb_complex_multiplier_axis;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Shared stimulus for the non-blocking default and OUT=16 instances
  logic [31:0] a_tdata = '0, b_tdata = '0;
  logic        a_tvalid = 1'b0, b_tvalid = 1'b0;
  logic        nb_a_tready, nb_b_tready, nb_dvalid;
  logic [65:0] nb_dout;
  logic        o16_a_tready, o16_b_tready, o16_dvalid;
  logic [31:0] o16_dout;

  // Blocking instance
  logic [31:0] k_a_tdata = '0, k_b_tdata = '0;
  logic        k_a_tvalid = 1'b0, k_b_tvalid = 1'b0, k_dready = 1'b0;
  logic        k_a_tready, k_b_tready, k_dvalid;
  logic [65:0] k_dout;

  // Byte-aligned 12x12 -> 25 instance
  logic [31:0] y_a_tdata = '0, y_b_tdata = '0;
  logic        y_a_tvalid = 1'b0, y_b_tvalid = 1'b0;
  logic        y_a_tready, y_b_tready, y_dvalid;
  logic [63:0] y_dout;

  complex_multiplier_axis #(.BLOCKING(1'b0)) u_nb (
    .aclk(clk), .aresetn(rst_n),
    .s_axis_a_tdata(a_tdata), .s_axis_a_tvalid(a_tvalid), .s_axis_a_tready(nb_a_tready),
    .s_axis_b_tdata(b_tdata), .s_axis_b_tvalid(b_tvalid), .s_axis_b_tready(nb_b_tready),
    .m_axis_dout_tdata(nb_dout), .m_axis_dout_tvalid(nb_dvalid), .m_axis_dout_tready(1'b1));

  complex_multiplier_axis #(.OPERAND_WIDTH_OUT(16), .BLOCKING(1'b0)) u_o16 (
    .aclk(clk), .aresetn(rst_n),
    .s_axis_a_tdata(a_tdata), .s_axis_a_tvalid(a_tvalid), .s_axis_a_tready(o16_a_tready),
    .s_axis_b_tdata(b_tdata), .s_axis_b_tvalid(b_tvalid), .s_axis_b_tready(o16_b_tready),
    .m_axis_dout_tdata(o16_dout), .m_axis_dout_tvalid(o16_dvalid), .m_axis_dout_tready(1'b1));

  complex_multiplier_axis #(.BLOCKING(1'b1)) u_blk (
    .aclk(clk), .aresetn(rst_n),
    .s_axis_a_tdata(k_a_tdata), .s_axis_a_tvalid(k_a_tvalid), .s_axis_a_tready(k_a_tready),
    .s_axis_b_tdata(k_b_tdata), .s_axis_b_tvalid(k_b_tvalid), .s_axis_b_tready(k_b_tready),
    .m_axis_dout_tdata(k_dout), .m_axis_dout_tvalid(k_dvalid), .m_axis_dout_tready(k_dready));

  complex_multiplier_axis #(.OPERAND_WIDTH_A(12), .OPERAND_WIDTH_B(12), .OPERAND_WIDTH_OUT(25),
                            .BYTE_ALIGNED(1'b1), .BLOCKING(1'b0)) u_ba (
    .aclk(clk), .aresetn(rst_n),
    .s_axis_a_tdata(y_a_tdata), .s_axis_a_tvalid(y_a_tvalid), .s_axis_a_tready(y_a_tready),
    .s_axis_b_tdata(y_b_tdata), .s_axis_b_tvalid(y_b_tvalid), .s_axis_b_tready(y_b_tready),
    .m_axis_dout_tdata(y_dout), .m_axis_dout_tvalid(y_dvalid), .m_axis_dout_tready(1'b1));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic longint cre(input logic [31:0] a, input logic [31:0] b);
    longint ar, ai, br, bi;
    ar = longint'($signed(a[15:0]));  ai = longint'($signed(a[31:16]));
    br = longint'($signed(b[15:0]));  bi = longint'($signed(b[31:16]));
    return ar * br - ai * bi;
  endfunction

  function automatic longint cim(input logic [31:0] a, input logic [31:0] b);
    longint ar, ai, br, bi;
    ar = longint'($signed(a[15:0]));  ai = longint'($signed(a[31:16]));
    br = longint'($signed(b[15:0]));  bi = longint'($signed(b[31:16]));
    return ar * bi + ai * br;
  endfunction

  function automatic logic [65:0] exp_full(input logic [31:0] a, input logic [31:0] b);
    longint r, i;
    r = cre(a, b);
    i = cim(a, b);
    return {i[32:0], r[32:0]};
  endfunction

  function automatic logic [31:0] exp_o16(input logic [31:0] a, input logic [31:0] b);
    longint r, i;
    r = cre(a, b) >>> 17;
    i = cim(a, b) >>> 17;
    return {i[15:0], r[15:0]};
  endfunction

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (3) step();
    n_tests++;
    if (nb_dvalid !== 1'b0 || nb_dout !== 66'd0) begin
      n_fail++; $display("FAIL reset_out got v=%b d=%h exp v=0 d=0", nb_dvalid, nb_dout);
    end
    n_tests++;
    if ({nb_a_tready, nb_b_tready, k_a_tready, k_b_tready} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_tready got %b exp 0000",
                         {nb_a_tready, nb_b_tready, k_a_tready, k_b_tready});
    end
    rst_n = 1'b1;
    n_tests++;
    if (nb_a_tready !== 1'b0) begin
      n_fail++; $display("FAIL release_tready_early got %b exp 0", nb_a_tready);
    end
    step();
    n_tests++;
    if ({nb_a_tready, nb_b_tready, k_a_tready, k_b_tready} !== 4'b1111) begin
      n_fail++; $display("FAIL release_tready got %b exp 1111",
                         {nb_a_tready, nb_b_tready, k_a_tready, k_b_tready});
    end
  endtask

  task automatic test_basic();
    a_tdata = {16'sd4, 16'sd3};
    b_tdata = {16'sd2, 16'sd1};
    a_tvalid = 1'b1; b_tvalid = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      a_tvalid = 1'b0; b_tvalid = 1'b0;
      n_tests++;
      if (nb_dvalid !== (k == 3) || o16_dvalid !== (k == 3)) begin
        n_fail++; $display("FAIL basic_valid k=%0d got %b/%b exp %b", k, nb_dvalid, o16_dvalid, k == 3);
      end
      if (k == 3 || k == 5) begin
        n_tests++;
        if (nb_dout !== {33'd10, 33'h1_FFFF_FFFB}) begin
          n_fail++; $display("FAIL basic_data k=%0d got %h exp re=-5 im=10", k, nb_dout);
        end
        n_tests++;
        if (o16_dout !== 32'h0000_FFFF) begin
          n_fail++; $display("FAIL basic_o16 k=%0d got %h exp 0000ffff", k, o16_dout);
        end
      end
    end
  endtask

  task automatic test_lone_valid();
    a_tdata = {16'sd7, 16'sd7};
    a_tvalid = 1'b1;
    step();
    a_tvalid = 1'b0;
    b_tvalid = 1'b1;
    step();
    b_tvalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (nb_dvalid !== 1'b0) begin
        n_fail++; $display("FAIL lone_valid k=%0d got %b exp 0", k, nb_dvalid);
      end
      step();
    end
  endtask

  task automatic test_extremes();
    a_tdata = 32'h8000_8000;
    b_tdata = 32'h8000_8000;
    a_tvalid = 1'b1; b_tvalid = 1'b1;
    step();
    a_tvalid = 1'b0; b_tvalid = 1'b0;
    step();
    step();
    n_tests++;
    if (nb_dvalid !== 1'b1 || nb_dout !== {33'h0_8000_0000, 33'd0}) begin
      n_fail++; $display("FAIL extreme_full got v=%b d=%h exp re=0 im=2^31", nb_dvalid, nb_dout);
    end
    n_tests++;
    if (o16_dvalid !== 1'b1 || o16_dout !== 32'h4000_0000) begin
      n_fail++; $display("FAIL extreme_o16 got v=%b d=%h exp 40000000", o16_dvalid, o16_dout);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] sa[64];
    logic [31:0] sb[64];
    for (int i = 0; i < 64; i++) begin
      sa[i] = $urandom();
      sb[i] = $urandom();
    end
    sa[0] = 32'h7FFF_8000;
    sb[0] = 32'h7FFF_7FFF;
    for (int c = 0; c <= 67; c++) begin
      if (c >= 3 && c < 67) begin
        n_tests++;
        if (nb_dvalid !== 1'b1 || nb_dout !== exp_full(sa[c-3], sb[c-3])) begin
          n_fail++; $display("FAIL stream[%0d] got v=%b d=%h exp %h", c - 3, nb_dvalid, nb_dout,
                             exp_full(sa[c-3], sb[c-3]));
        end
        n_tests++;
        if (o16_dvalid !== 1'b1 || o16_dout !== exp_o16(sa[c-3], sb[c-3])) begin
          n_fail++; $display("FAIL stream_o16[%0d] got v=%b d=%h exp %h", c - 3, o16_dvalid, o16_dout,
                             exp_o16(sa[c-3], sb[c-3]));
        end
      end else if (c == 67) begin
        n_tests++;
        if (nb_dvalid !== 1'b0) begin
          n_fail++; $display("FAIL stream_tail got %b exp 0", nb_dvalid);
        end
      end
      if (c < 64) begin
        a_tdata = sa[c]; b_tdata = sb[c];
        a_tvalid = 1'b1; b_tvalid = 1'b1;
      end else begin
        a_tvalid = 1'b0; b_tvalid = 1'b0;
      end
      step();
    end
  endtask

  task automatic test_byte_aligned();
    logic [31:0] va[3];
    logic [31:0] vb[3];
    logic [63:0] ve[3];
    va[0] = {4'hA, 12'h000, 4'h5, 12'hFFF};  vb[0] = {4'hF, 12'h000, 4'h3, 12'h001};
    ve[0] = {32'h0000_0000, 32'hFFFF_FFFF};
    va[1] = {4'h9, 12'hFCE, 4'h6, 12'h064};  vb[1] = {4'hC, 12'h007, 4'hE, 12'hFFD};
    ve[1] = {32'd850, 32'd50};
    va[2] = {4'h7, 12'hFFF, 4'h7, 12'h000};  vb[2] = {4'h8, 12'h000, 4'h8, 12'h002};
    ve[2] = {32'hFFFF_FFFE, 32'h0000_0000};
    for (int c = 0; c <= 6; c++) begin
      if (c >= 3 && c <= 5) begin
        n_tests++;
        if (y_dvalid !== 1'b1 || y_dout !== ve[c-3]) begin
          n_fail++; $display("FAIL byte_aligned[%0d] got v=%b d=%h exp %h", c - 3, y_dvalid, y_dout, ve[c-3]);
        end
      end else if (c == 6) begin
        n_tests++;
        if (y_dvalid !== 1'b0) begin
          n_fail++; $display("FAIL byte_aligned_tail got %b exp 0", y_dvalid);
        end
      end
      if (c < 3) begin
        y_a_tdata = va[c]; y_b_tdata = vb[c];
        y_a_tvalid = 1'b1; y_b_tvalid = 1'b1;
      end else begin
        y_a_tvalid = 1'b0; y_b_tvalid = 1'b0;
      end
      step();
    end
  endtask

  task automatic test_blocking();
    localparam int N = 24;
    logic [31:0] ka[N];
    logic [31:0] kb[N];
    logic [65:0] prev_data;
    int  ai = 0, bi = 0, oi = 0, cyc = 0;
    bit  a_fired = 1'b0, b_fired = 1'b0, prev_stall = 1'b0;
    for (int i = 0; i < N; i++) begin
      ka[i] = $urandom();
      kb[i] = $urandom();
    end
    prev_data = '0;
    while (oi < N && cyc < 3000) begin
      if (a_fired) begin
        n_tests++;
        if (k_a_tready !== 1'b0) begin
          n_fail++; $display("FAIL blk_a_tready_full cyc=%0d got %b exp 0", cyc, k_a_tready);
        end
        ai++;
        k_a_tvalid = 1'b0;
      end
      if (b_fired) begin
        n_tests++;
        if (k_b_tready !== 1'b0) begin
          n_fail++; $display("FAIL blk_b_tready_full cyc=%0d got %b exp 0", cyc, k_b_tready);
        end
        bi++;
        k_b_tvalid = 1'b0;
      end
      if (prev_stall) begin
        n_tests++;
        if (k_dvalid !== 1'b1 || k_dout !== prev_data) begin
          n_fail++; $display("FAIL blk_stall_stable cyc=%0d got v=%b d=%h exp v=1 d=%h",
                             cyc, k_dvalid, k_dout, prev_data);
        end
      end
      if (!k_a_tvalid && ai < N && $urandom_range(0, 2) != 0) begin
        k_a_tdata = ka[ai]; k_a_tvalid = 1'b1;
      end
      if (!k_b_tvalid && bi < N && $urandom_range(0, 2) != 0) begin
        k_b_tdata = kb[bi]; k_b_tvalid = 1'b1;
      end
      k_dready = 1'($urandom_range(0, 1));
      a_fired = k_a_tvalid && k_a_tready;
      b_fired = k_b_tvalid && k_b_tready;
      if (k_dvalid && k_dready) begin
        n_tests++;
        if (k_dout !== exp_full(ka[oi], kb[oi])) begin
          n_fail++; $display("FAIL blk_out[%0d] got %h exp %h", oi, k_dout, exp_full(ka[oi], kb[oi]));
        end
        oi++;
      end
      prev_stall = k_dvalid && !k_dready;
      prev_data  = k_dout;
      step();
      cyc++;
    end
    n_tests++;
    if (oi != N) begin
      n_fail++; $display("FAIL blk_timeout got %0d outputs exp %0d", oi, N);
    end
    k_a_tvalid = 1'b0; k_b_tvalid = 1'b0; k_dready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      n_tests++;
      if (k_dvalid !== 1'b0) begin
        n_fail++; $display("FAIL blk_extra_output k=%0d got %b exp 0", k, k_dvalid);
      end
      step();
    end
  endtask

  task automatic test_reset_midstream();
    logic [31:0] pa[3];
    logic [31:0] pb[3];
    pa[0] = {16'sd1, 16'sd1};  pb[0] = {16'sd1, 16'sd1};
    pa[1] = {16'sd0, 16'sd2};  pb[1] = {16'sd0, 16'sd3};
    pa[2] = {16'sd0, 16'sd5};  pb[2] = {16'sd0, 16'sd5};
    for (int c = 0; c < 3; c++) begin
      a_tdata = pa[c]; b_tdata = pb[c];
      a_tvalid = 1'b1; b_tvalid = 1'b1;
      step();
    end
    a_tvalid = 1'b0; b_tvalid = 1'b0;
    n_tests++;
    if (nb_dvalid !== 1'b1 || nb_dout !== {33'd2, 33'd0}) begin
      n_fail++; $display("FAIL midrst_first got v=%b d=%h exp re=0 im=2", nb_dvalid, nb_dout);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (nb_dvalid !== 1'b0 || nb_dout !== 66'd0 || nb_a_tready !== 1'b0) begin
      n_fail++; $display("FAIL midrst_async got v=%b d=%h rdy=%b exp 0/0/0", nb_dvalid, nb_dout, nb_a_tready);
    end
    step();
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      n_tests++;
      if (nb_dvalid !== 1'b0) begin
        n_fail++; $display("FAIL midrst_dropped k=%0d got %b exp 0", k, nb_dvalid);
      end
    end
    a_tdata = {16'sd3, 16'hFFFE};
    b_tdata = {16'hFFFF, 16'sd4};
    a_tvalid = 1'b1; b_tvalid = 1'b1;
    step();
    a_tvalid = 1'b0; b_tvalid = 1'b0;
    step();
    step();
    n_tests++;
    if (nb_dvalid !== 1'b1 || nb_dout !== {33'd14, 33'h1_FFFF_FFFB}) begin
      n_fail++; $display("FAIL midrst_new got v=%b d=%h exp re=-5 im=14", nb_dvalid, nb_dout);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lone_valid();
    test_extremes();
    test_back_to_back();
    test_byte_aligned();
    test_blocking();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog expired tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
